// File: rtl/usb_txf.sv
// usb_txf -- byte-to-nibble link framer.
//
// Buffers upstream payload bytes in a DEPTH-entry FIFO of {last, byte} and
// serialises each packet onto a 4-bit lane as:
//   PRE_LEN x 0x0 preamble, one 0xF sync nibble, then every byte as
//   high nibble / low nibble back-to-back, then a 2-cycle gap.
// fire qualifies the frame and drops on the low nibble of the frame's last
// byte. A frame is at most DEPTH bytes; if the FIFO fills without holding a
// complete packet, a DEPTH-byte frame is forced out and err_trunc pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        payload byte
//   din_valid  din/din_last valid
//   din_last   din is the final byte of a packet
//   din_ready  byte accepted when high together with din_valid
//   dout       nibble lane (registered)
//   fire       frame-active qualifier (registered)
//   busy       high from preamble to end of gap (registered)
//   err_trunc  one-cycle pulse when a frame is forcibly truncated
//   dbg_state  current FSM state (IDLE=0 PRE=1 SYNC=2 HI=3 LO=4 GAP=5)
//
// Handshake: a byte transfers on a rising edge where din_valid and din_ready
// are both high; din_valid may be held or dropped freely, din_ready depends
// only on FIFO fullness and reset, never on din_valid.
module usb_txf #(
  parameter int PRE_LEN = 2,
  parameter int DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [3:0] dout,
  output logic       fire,
  output logic       busy,
  output logic       err_trunc,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SYNC = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [3:0]    PRE_END  = 4'(PRE_LEN - 1);

  // FIFO storage: bit 8 is the packet-last flag.
  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_q, pkt_d;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] nbytes_q, nbytes_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;

  logic [3:0]    dout_q, dout_d;
  logic          fire_q, fire_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  assign full      = (count_q == DEPTH_C);
  assign din_ready = ~full & rst;
  assign push      = din_valid & din_ready;
  assign head      = mem_q[rd_ptr_q];

  assign dout      = dout_q;
  assign fire      = fire_q;
  assign busy      = busy_q;
  assign err_trunc = err_q;
  assign dbg_state = state_q;

  // FIFO pointers, occupancy and complete-packet count. A push and a pop on
  // the same edge cancel in both counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    pkt_d   = pkt_q + CW'(push & din_last) - CW'(pop & head[8]);
  end

  // Frame sequencer. The pop happens on the edge that enters HI, so the
  // popped byte is available to the output registers on that same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    byte_d   = byte_q;
    last_d   = last_q;
    pop      = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pkt_q != '0 || full) begin
          state_d  = S_PRE;
          cnt_d    = 4'd0;
          nbytes_d = '0;
          // Full with no complete packet: the frame is cut at DEPTH bytes.
          err_d    = full && (pkt_q == '0);
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_END) state_d = S_SYNC;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      S_SYNC: begin
        state_d = S_HI;
        pop     = 1'b1;
      end
      S_HI: state_d = S_LO;
      S_LO: begin
        if (last_q) begin
          state_d = S_GAP;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_HI;
          pop     = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      byte_d   = head[7:0];
      // Frame ends at the first stored last flag or at the DEPTH-th byte.
      last_d   = head[8] || (nbytes_q == LAST_IDX);
      nbytes_d = nbytes_q + CW'(1);
    end
  end

  // Outputs are a function of the state being entered, then registered.
  always_comb begin
    dout_d = 4'h0;
    fire_d = 1'b0;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_PRE:  fire_d = 1'b1;
      S_SYNC: begin
        dout_d = 4'hF;
        fire_d = 1'b1;
      end
      S_HI: begin
        dout_d = byte_d[7:4];
        fire_d = 1'b1;
      end
      S_LO: begin
        dout_d = byte_d[3:0];
        fire_d = ~last_d;
      end
      S_GAP:   busy_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {din_last, din};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      nbytes_q <= '0;
      byte_q   <= 8'h00;
      last_q   <= 1'b0;
      dout_q   <= 4'h0;
      fire_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      fire_q   <= fire_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

endmodule
